// File: rtl/dual_ram_pkg.sv
// Shared defaults and FSM encoding for the dual_ram read-stream engine.
package dual_ram_pkg;

    localparam int RAM_WIDTH = 8;
    localparam int RAM_DEPTH = 16;
    localparam int ADDR_SIZE = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN
    } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo2.sv
// Two-entry FIFO holding {last, data} words between the RAM read port and the stream.
module rd_skid_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    // A push into a full FIFO is only accepted when a pop frees a slot this cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/dual_ram_rd_stream.sv
// Read-side engine for dual_ram: reads a burst of words starting at base_addr
// and streams them out on a valid/ready interface with a last marker.
// Optional feature macro RD_STREAM_LOOP_EN adds a 'loop' input that makes the
// burst repeat forever (exit only by reset).
module dual_ram_rd_stream
    import dual_ram_pkg::*;
#(
    parameter int RAM_WIDTH = dual_ram_pkg::RAM_WIDTH,
    parameter int RAM_DEPTH = dual_ram_pkg::RAM_DEPTH,
    parameter int ADDR_SIZE = dual_ram_pkg::ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [ADDR_SIZE:0]   length,
`ifdef RD_STREAM_LOOP_EN
    input  logic                 loop,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 ram_read,
    output logic [ADDR_SIZE-1:0] ram_rd_addr,
    input  logic [RAM_WIDTH-1:0] ram_data,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready
);

    rd_state_t            state, state_n;
    logic [ADDR_SIZE-1:0] addr, addr_n, base_q, base_n;
    logic [ADDR_SIZE:0]   rem, rem_n, len_q, len_n, len_clamped;
    logic                 loop_q, loop_n, loop_in;
    logic                 done_n;
    logic                 in_flight, in_flight_last;
    logic                 issue, pop;
    logic [2:0]           used;
    logic [1:0]           fifo_count;
    logic                 fifo_full, fifo_empty;
    logic [RAM_WIDTH:0]   fifo_dout;

`ifdef RD_STREAM_LOOP_EN
    assign loop_in = loop;
`else
    assign loop_in = 1'b0;
`endif

    assign len_clamped = (length > (ADDR_SIZE+1)'(RAM_DEPTH)) ? (ADDR_SIZE+1)'(RAM_DEPTH) : length;

    // Slots committed after this cycle: buffered + in flight, minus a word leaving now.
    // Counting the pop keeps one word per cycle flowing with m_ready held high.
    assign pop   = m_valid & m_ready;
    assign used  = {1'b0, fifo_count} + {2'b0, in_flight} - {2'b0, pop};
    assign issue = (state == RUN) && (rem != '0) && (used < 3'd2) && !(fifo_full && !pop);

    assign busy        = (state != IDLE);
    assign ram_read    = issue;
    assign ram_rd_addr = addr;
    assign m_valid     = ~fifo_empty;
    assign m_data      = fifo_dout[RAM_WIDTH-1:0];
    assign m_last      = m_valid & fifo_dout[RAM_WIDTH];

    // Next-state, counter and done logic.
    always_comb begin
        state_n = state;
        addr_n  = addr;
        rem_n   = rem;
        base_n  = base_q;
        len_n   = len_q;
        loop_n  = loop_q;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = RUN;
                        addr_n  = base_addr;
                        rem_n   = len_clamped;
                        base_n  = base_addr;
                        len_n   = len_clamped;
                        loop_n  = loop_in;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_n = addr + ADDR_SIZE'(1);
                    rem_n  = rem - (ADDR_SIZE+1)'(1);
                    if (rem == (ADDR_SIZE+1)'(1)) begin
                        if (loop_q) begin
                            // Restart the pass with no idle cycle.
                            addr_n = base_q;
                            rem_n  = len_q;
                        end else begin
                            state_n = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and the one-deep in-flight read tracker.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            addr           <= '0;
            rem            <= '0;
            base_q         <= '0;
            len_q          <= '0;
            loop_q         <= 1'b0;
            done           <= 1'b0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            state          <= state_n;
            addr           <= addr_n;
            rem            <= rem_n;
            base_q         <= base_n;
            len_q          <= len_n;
            loop_q         <= loop_n;
            done           <= done_n;
            in_flight      <= issue;
            in_flight_last <= issue && (rem == (ADDR_SIZE+1)'(1));
        end
    end

    // RAM data arrives the cycle after the read and is captured unconditionally.
    rd_skid_fifo2 #(.W(RAM_WIDTH+1)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_flight),
        .din   ({in_flight_last, ram_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_dual_ram_rd_stream.sv
// Directed bench for dual_ram_rd_stream with a behavioural one-cycle-latency RAM.
module tb_dual_ram_rd_stream;

    logic       clk = 1'b0;
    logic       reset, start, loop, m_ready;
    logic [3:0] base_addr, ram_rd_addr;
    logic [4:0] length;
    logic       busy, done, ram_read, m_valid, m_last;
    logic [7:0] ram_data, m_data;
    logic [7:0] mem [16];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [8:0] wq[$];
    int         wcyc[$];
    int         aq[$];
    int         done_cnt  = 0;
    int         valid_cnt = 0;
    int         max_occ   = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_out   = '0;

    dual_ram_rd_stream dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
`ifdef RD_STREAM_LOOP_EN
        .loop        (loop),
`endif
        .busy        (busy),
        .done        (done),
        .ram_read    (ram_read),
        .ram_rd_addr (ram_rd_addr),
        .ram_data    (ram_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM read port: data valid the cycle after the read request.
    always @(posedge clk) if (ram_read) ram_data <= mem[ram_rd_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: handshakes, read addresses, done pulses, occupancy, stall stability.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold", {22'd0, m_valid, m_last, m_data}, {22'd0, prev_out});
            if (m_valid && m_ready) begin
                wq.push_back({m_last, m_data});
                wcyc.push_back(cyc);
            end
            if (m_valid) valid_cnt <= valid_cnt + 1;
            if (ram_read) aq.push_back(int'(ram_rd_addr));
            if (done) done_cnt <= done_cnt + 1;
            if (int'(dut.u_fifo.count) > max_occ) max_occ <= int'(dut.u_fifo.count);
            prev_stall <= m_valid & ~m_ready;
            prev_out   <= {m_valid, m_last, m_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        wq.delete();
        wcyc.delete();
        aq.delete();
    endtask

    task automatic go(input logic [3:0] b, input logic [4:0] l, input logic lp);
        start = 1'b1; base_addr = b; length = l; loop = lp;
        tick();
        // Scramble the parameters to show they are only sampled at start.
        start = 1'b0; base_addr = 4'hf; length = 5'd0; loop = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        tick();
    endtask

    // Compare captured words against base..base+per-1 repeated, last on each pass end.
    task automatic chk_words(input string tag, input int b, input int n, input int per);
        for (int i = 0; i < n; i++) begin
            if (i < wq.size()) begin
                chk($sformatf("%s_data%0d", tag, i), {24'd0, wq[i][7:0]}, 32'h10 + ((b + i % per) % 16));
                chk($sformatf("%s_last%0d", tag, i), {31'd0, wq[i][8]}, {31'd0, (i % per) == per - 1});
            end
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_read"}, {31'd0, ram_read}, 32'd0);
        chk({tag, "_addr"}, {28'd0, ram_rd_addr}, 32'd0);
        chk({tag, "_valid"}, {31'd0, m_valid}, 32'd0);
        chk({tag, "_last"}, {31'd0, m_last}, 32'd0);
        chk({tag, "_data"}, {24'd0, m_data}, 32'd0);
        chk({tag, "_state"}, {30'd0, dut.state}, 32'd0);
    endtask

    initial begin
        int d0, v0;
        for (int a = 0; a < 16; a++) mem[a] = 8'h10 + 8'(a);
        reset = 1'b1; start = 1'b0; loop = 1'b0; m_ready = 1'b1;
        base_addr = '0; length = '0;
        repeat (3) tick();
        @(negedge clk);
        chk_zero_outputs("rst");
        tick();
        reset = 1'b0;
        tick();

        // Test 1: base 3, len 5, continuous ready.
        clear_q();
        go(4'd3, 5'd5, 1'b0);
        wait_done("t1", 30);
        chk("t1_count", wq.size(), 5);
        chk_words("t1", 3, 5, 5);
        for (int i = 1; i < 5; i++)
            if (i < wcyc.size()) chk($sformatf("t1_gap%0d", i), wcyc[i] - wcyc[0], i);
        chk("t1_busy_after", {31'd0, busy}, 32'd0);

        // Test 2: wrap-around addressing.
        clear_q();
        go(4'd14, 5'd4, 1'b0);
        wait_done("t2", 30);
        chk("t2_nreads", aq.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < aq.size()) chk($sformatf("t2_addr%0d", i), aq[i], (14 + i) % 16);
        chk("t2_count", wq.size(), 4);
        chk_words("t2", 14, 4, 4);

        // Test 3: full-depth burst with toggling then stalled ready.
        clear_q();
        max_occ = 0;
        d0 = done_cnt;
        go(4'd0, 5'd16, 1'b0);
        for (int k = 0; k < 200; k++) begin
            m_ready = (k < 10) ? (k % 2 == 0) : (k < 15) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (done) break;
            tick();
        end
        chk("t3_done", done_cnt - d0 + {31'd0, done}, 1);
        tick();
        m_ready = 1'b1;
        chk("t3_count", wq.size(), 16);
        chk_words("t3", 0, 16, 16);
        chk("t3_occ_max", {31'd0, max_occ <= 2}, 32'd1);

        // Test 4: zero length, then a start while busy.
        clear_q();
        d0 = done_cnt; v0 = valid_cnt;
        go(4'd6, 5'd0, 1'b0);
        @(negedge clk);
        chk("t4_done_pulse", {31'd0, done}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        chk("t4_done_once", done_cnt - d0, 1);
        chk("t4_no_reads", aq.size(), 0);
        chk("t4_no_valid", valid_cnt - v0, 0);
        d0 = done_cnt;
        go(4'd8, 5'd3, 1'b0);
        start = 1'b1; base_addr = 4'd0; length = 5'd3;
        tick();
        start = 1'b0;
        wait_done("t4b", 30);
        repeat (5) tick();
        chk("t4b_count", wq.size(), 3);
        chk_words("t4b", 8, 3, 3);
        chk("t4b_reads", aq.size(), 3);
        chk("t4b_done_once", done_cnt - d0, 1);

        // Test 5: reset in the middle of a burst.
        go(4'd0, 5'd8, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk_zero_outputs("t5");
        tick();
        reset = 1'b0;
        clear_q();
        d0 = done_cnt;
        repeat (3) tick();
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_no_words", wq.size(), 0);
        go(4'd5, 5'd2, 1'b0);
        wait_done("t5b", 30);
        chk("t5b_count", wq.size(), 2);
        chk_words("t5b", 5, 2, 2);

`ifdef RD_STREAM_LOOP_EN
        // Test 6: looping burst.
        clear_q();
        d0 = done_cnt;
        go(4'd2, 5'd3, 1'b1);
        repeat (16) tick();
        chk("t6_enough", {31'd0, wq.size() >= 9}, 32'd1);
        chk_words("t6", 2, 9, 3);
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
